// File: rtl/adaptor2x2_imem_arbiter_if.sv
// One instruction-memory master port (Avalon-MM style word bus).
// The lock strobe exists only when IMEM_ARB_LOCK_EN is defined.
interface adaptor2x2_imem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W / 8
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [BE_W-1:0]   byteenable;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
`ifdef IMEM_ARB_LOCK_EN
  logic              lock;
`endif

  modport master (
`ifdef IMEM_ARB_LOCK_EN
    output lock,
`endif
    output address, read, write, byteenable, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
`ifdef IMEM_ARB_LOCK_EN
    input  lock,
`endif
    input  address, read, write, byteenable, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/adaptor2x2_imem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port instruction RAM.
// Optional bus locking is compiled in with the IMEM_ARB_LOCK_EN macro.
//
// Handshake: a master command (read|write) is accepted in a cycle where
// waitrequest=0; reads return exactly one cycle later on readdatavalid.
module adaptor2x2_imem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic                       clk,
  input  logic                       reset,
  adaptor2x2_imem_arbiter_if.slave   m0,
  adaptor2x2_imem_arbiter_if.slave   m1,
  output logic [ADDR_W-1:0]          mem_address,
  output logic [BE_W-1:0]            mem_byteenable,
  output logic [DATA_W-1:0]          mem_writedata,
  output logic                       mem_chipselect,
  output logic                       mem_write,
  output logic                       mem_clken,
  input  logic [DATA_W-1:0]          mem_readdata
);

  logic req0, req1;
  logic gnt0, gnt1;
  logic any_gnt;
  logic gnt_write;
  logic last_grant;
  logic rd_pend;
  logic rd_tag;

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

`ifdef IMEM_ARB_LOCK_EN
  logic locked;
  logic owner;
  logic gnt_lock;

  // While locked only the owner may be granted, even if it is idle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (locked) begin
      gnt0 = req0 & (owner == 1'b0);
      gnt1 = req1 & (owner == 1'b1);
    end else begin
      gnt0 = req0 & (~req1 | (last_grant == 1'b1));
      gnt1 = req1 & (~req0 | (last_grant == 1'b0));
    end
  end

  assign gnt_lock = gnt1 ? m1.lock : m0.lock;

  // Lock takes effect after the accepted command; an unlocked owner command releases it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked <= 1'b0;
      owner  <= 1'b0;
    end else if (any_gnt) begin
      if (gnt_lock) begin
        locked <= 1'b1;
        owner  <= gnt1;
      end else begin
        locked <= 1'b0;
      end
    end
  end
`else
  always_comb begin
    gnt0 = req0 & (~req1 | (last_grant == 1'b1));
    gnt1 = req1 & (~req0 | (last_grant == 1'b0));
  end
`endif

  assign any_gnt   = gnt0 | gnt1;
  assign gnt_write = gnt1 ? m1.write : (gnt0 & m0.write);

  assign m0.waitrequest = req0 & ~gnt0;
  assign m1.waitrequest = req1 & ~gnt1;

  // Master 0 drives the RAM address/data whenever master 1 is not granted.
  assign mem_address    = gnt1 ? m1.address    : m0.address;
  assign mem_byteenable = gnt1 ? m1.byteenable : m0.byteenable;
  assign mem_writedata  = gnt1 ? m1.writedata  : m0.writedata;
  assign mem_chipselect = any_gnt;
  assign mem_write      = gnt_write;
  assign mem_clken      = 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      rd_pend    <= 1'b0;
      rd_tag     <= 1'b0;
    end else begin
      if (any_gnt) begin
        last_grant <= gnt1;
      end
      // A simultaneous read+write is a write and produces no return.
      rd_pend <= any_gnt & ~gnt_write;
      rd_tag  <= gnt1;
    end
  end

  assign m0.readdatavalid = rd_pend & (rd_tag == 1'b0);
  assign m1.readdatavalid = rd_pend & (rd_tag == 1'b1);
  assign m0.readdata      = mem_readdata;
  assign m1.readdata      = mem_readdata;

endmodule
